ss_scan: RTL and testbench
==========================

SS_SCAN -- requirements
Module: ss_scan

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed 7-segment digits, legal range 2..8.
REQ-002 Parameter DIV, default 50000: clk cycles each digit is shown, legal range 2..2^20.
REQ-003 Parameter BLANK_CYC, default 16: clk cycles of all-off anti-ghosting gap after each digit, legal range 1..255.
REQ-004 clk  input  1  sole clock, all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 load  input  1  single-cycle strobe that captures data.
REQ-007 data  input  4*DIGITS  hex value; nibble k drives digit k, with digit 0 rightmost.
REQ-008 nibble  output  4  hex code of the active digit, fed to the downstream hex-to-7seg decoder.
REQ-009 an  output  DIGITS  anode enables, active-low, at most one bit low at any time.
REQ-010 pend  output  1  high while captured data awaits the frame boundary.
REQ-011 frame  output  1  one-cycle pulse at every frame boundary.

Function
REQ-012 The block SHALL implement a two-state FSM: SHOW, followed by BLANK, returning to SHOW.
- SHOW: lasts exactly DIV cycles; an = ~(1<<idx); nibble = shadow[4*idx+3:4*idx].
- BLANK: lasts exactly BLANK_CYC cycles; an = all ones; nibble holds its last value.
REQ-013 On the BLANK->SHOW transition, idx SHALL increment, wrapping from DIGITS-1 to 0; frame period = DIGITS*(DIV+BLANK_CYC) cycles.
REQ-014 A load strobe SHALL write data into the pending register and set pend on the next edge; a later load before the boundary SHALL overwrite pending, last one wins.
REQ-015 Frame boundary = the BLANK->SHOW transition into idx 0; on that edge, if pend=1, shadow SHALL take pending, pend SHALL clear, and frame SHALL pulse for one cycle.
REQ-016 If load coincides with the boundary edge, data SHALL go straight into shadow and pend SHALL end at 0.
REQ-017 Shadow SHALL change only at frame boundaries, so no frame ever displays mixed old and new digits.
REQ-018 All outputs SHALL be driven from registers only, with no combinational path from load or data.
REQ-019 The internal down-counter SHALL be sized $clog2(max(DIV,BLANK_CYC)) bits and SHALL reload at each state change, never free-running.

Reset
REQ-020 While rst=1, the block SHALL hold an = all ones, nibble = 0, pend = 0 and frame = 0, and SHALL clear shadow, pending, idx and the counter to 0, all immediately and asynchronously.
REQ-021 On the first edge after rst deasserts, the block SHALL enter SHOW with idx = 0.
REQ-022 Reset mid-frame SHALL discard pending data and restart the scan at idx 0 without emitting a frame pulse.

Configuration
REQ-023 With SS_SCAN_LZB_EN defined, leading-zero blanking SHALL apply: in SHOW for idx > 0, if shadow nibbles idx..DIGITS-1 are all 0, an SHALL stay all ones while timing stays unchanged, and digit 0 SHALL always be lit.
REQ-024 Without SS_SCAN_LZB_EN, every digit SHALL be lit in its SHOW slot, and no blanking logic SHALL be synthesized.

Structure
REQ-025 Shared package ss_pkg SHALL hold the state enum (SS_SHOW, SS_BLANK), the DIGITS default, and a function returning the one-hot active-low anode pattern.
REQ-026 The counter and reload logic SHALL live in sub-module ss_tick_gen, which outputs a one-cycle expire pulse.
REQ-027 The hex-to-7seg decoder SHALL be instantiated beside ss_scan at top level, not inside it.

Verification (DIGITS=4, DIV=4, BLANK_CYC=1 unless noted)
REQ-028 Release rst, no load -> an sequence 1110 x4, 1111 x1, 1101 x4, 1111 x1, and so on; nibble = 0; first frame pulse 20 cycles after the first SHOW cycle.
REQ-029 load with data=16'hA5C3 mid-frame -> pend=1 until the boundary, then frame pulse, pend=0; next frame nibble = 3,C,5,A on digits 0..3.
REQ-030 Two loads (16'h1111 then 16'h2222) inside one frame -> only 2 appears on any digit; 1 never displayed.
REQ-031 load with data=16'hBEEF on the boundary edge -> shadow=16'hBEEF that frame, pend stays 0.
REQ-032 Assert rst during BLANK of idx 2 -> an=1111 immediately; after release, SHOW idx 0 with nibble 0; no frame pulse.
REQ-033 With SS_SCAN_LZB_EN defined and data=16'h0070 -> an low only in slots 0 and 1; data=16'h0000 -> only digit 0 lit, showing 0.

Source files
------------

// File: rtl/ss_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scanner.
package ss_pkg;

  typedef enum logic {
    SS_SHOW,
    SS_BLANK
  } ss_state_e;

  localparam int SS_DIGITS_DEF = 4;

  // One-hot active-low anode pattern for up to eight digits; callers truncate.
  function automatic logic [7:0] ss_an_pattern(input logic [2:0] idx);
    return ~(8'd1 << idx);
  endfunction

endpackage

// File: rtl/ss_tick_gen.sv
// Down-counter timing one SHOW or BLANK slot; reloads only when told to.
module ss_tick_gen #(
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic reload_i,
  input  logic show_i,
  output logic expire_o
);
  localparam int MAX_C = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
  localparam int W     = $clog2(MAX_C);
  localparam logic [W-1:0] SHOW_LD  = W'(DIV - 1);
  localparam logic [W-1:0] BLANK_LD = W'(BLANK_CYC - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q - 1'b1;
    if (reload_i) cnt_d = show_i ? SHOW_LD : BLANK_LD;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/ss_scan.sv
// Multiplexed 7-segment scanner with frame-synchronous data update; the hex
// decoder sits beside this block. Define SS_SCAN_LZB_EN for leading-zero blanking.
module ss_scan
  import ss_pkg::*;
#(
  parameter int DIGITS    = SS_DIGITS_DEF,
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] data,
  output logic [3:0]          nibble,
  output logic [DIGITS-1:0]   an,
  output logic                pend,
  output logic                frame
);
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  ss_state_e           state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d, pending_q, pending_d;
  logic                pend_q, pend_d, frame_q, frame_d, run_q;
  logic [3:0]          nibble_q, nibble_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                expire, step, boundary;

  // run_q forces a SHOW reload on the first edge after reset instead of a slot change.
  assign step     = run_q & expire;
  assign boundary = step & (state_q == SS_BLANK) & (idx_q == LAST_IDX);

  ss_tick_gen #(
    .DIV       (DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .reload_i (step | ~run_q),
    .show_i   (state_d == SS_SHOW),
    .expire_o (expire)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    pend_d    = pend_q;
    frame_d   = boundary;
    an_d      = '1;
    nibble_d  = nibble_q;

    if (step) begin
      if (state_q == SS_SHOW) begin
        state_d = SS_BLANK;
      end else begin
        state_d = SS_SHOW;
        idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end
    end

    if (boundary) begin
      pend_d = 1'b0;
      if (load)        shadow_d = data;
      else if (pend_q) shadow_d = pending_q;
    end else if (load) begin
      pending_d = data;
      pend_d    = 1'b1;
    end

    // Outputs are registered from next-state values so they line up with the slot.
    if (state_d == SS_SHOW) begin
      an_d     = DIGITS'(ss_an_pattern(3'(idx_d)));
      nibble_d = shadow_d[{idx_d, 2'b00} +: 4];
`ifdef SS_SCAN_LZB_EN
      if (idx_d != '0 && (shadow_d >> {idx_d, 2'b00}) == '0) an_d = '1;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SS_SHOW;
      idx_q     <= '0;
      shadow_q  <= '0;
      pending_q <= '0;
      pend_q    <= 1'b0;
      frame_q   <= 1'b0;
      run_q     <= 1'b0;
      an_q      <= '1;
      nibble_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      pend_q    <= pend_d;
      frame_q   <= frame_d;
      run_q     <= 1'b1;
      an_q      <= an_d;
      nibble_q  <= nibble_d;
    end
  end

  assign nibble = nibble_q;
  assign an     = an_q;
  assign pend   = pend_q;
  assign frame  = frame_q;

endmodule

// File: tb/tb_ss_scan.sv
// Scoreboard bench for ss_scan (DIGITS=4, DIV=4, BLANK_CYC=1); the
// leading-zero test is built only when SS_SCAN_LZB_EN is defined.
module tb_ss_scan;
  localparam int DIGITS    = 4;
  localparam int DIV       = 4;
  localparam int BLANK_CYC = 1;
  localparam int SLOT      = DIV + BLANK_CYC;
  localparam int FRAME     = DIGITS * SLOT;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] nib;
    logic       frame;
    logic       pend;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  nibble;
  logic [3:0]  an;
  logic        pend;
  logic        frame;

  int errors = 0;
  int checks = 0;

  exp_t        exp_q[$];
  int          m_pos = -1;
  bit          m_started = 1'b0;
  logic [15:0] m_shadow = '0;
  logic [15:0] m_pending = '0;
  logic        m_pend = 1'b0;
  logic [3:0]  m_nib = '0;

  ss_scan #(
    .DIGITS    (DIGITS),
    .DIV       (DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .data   (data),
    .nibble (nibble),
    .an     (an),
    .pend   (pend),
    .frame  (frame)
  );

  always #5 clk = ~clk;

  // Position-in-frame model: predicts outputs for the cycle following each edge.
  always @(posedge clk or posedge rst) begin
    exp_t        e;
    int          slot;
    int          sub;
    logic [15:0] upper;
    logic        bnd;
    if (rst) begin
      m_started = 1'b0;
      m_pos     = -1;
      m_shadow  = '0;
      m_pending = '0;
      m_pend    = 1'b0;
      m_nib     = '0;
      exp_q.delete();
    end else begin
      bnd = 1'b0;
      if (!m_started) begin
        m_started = 1'b1;
        m_pos     = 0;
      end else begin
        m_pos = (m_pos + 1) % FRAME;
        bnd   = (m_pos == 0);
      end
      if (bnd) begin
        if (load)        m_shadow = data;
        else if (m_pend) m_shadow = m_pending;
        m_pend = 1'b0;
      end else if (load) begin
        m_pending = data;
        m_pend    = 1'b1;
      end
      slot    = m_pos / SLOT;
      sub     = m_pos % SLOT;
      e.an    = 4'hF;
      e.frame = bnd;
      e.pend  = m_pend;
      if (sub < DIV) begin
        m_nib = m_shadow[4*slot +: 4];
        e.an  = ~(4'b0001 << slot);
`ifdef SS_SCAN_LZB_EN
        upper = m_shadow >> (4 * slot);
        if (slot > 0 && upper == 16'h0) e.an = 4'hF;
`else
        upper = '0;
`endif
      end
      e.nib = m_nib;
      exp_q.push_back(e);
    end
  end

  task automatic next_cycle(output exp_t e);
    @(negedge clk);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else                  e = 'x;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    load = 1'b1;
    data = 16'h1234;
    repeat (3) @(negedge clk);
    checks++; if (an !== 4'hF)     begin errors++; $display("FAIL reset_an got=%b exp=1111", an); end
    checks++; if (nibble !== 4'h0) begin errors++; $display("FAIL reset_nibble got=%h exp=0", nibble); end
    checks++; if (pend !== 1'b0)   begin errors++; $display("FAIL reset_pend got=%b exp=0", pend); end
    checks++; if (frame !== 1'b0)  begin errors++; $display("FAIL reset_frame got=%b exp=0", frame); end
    load = 1'b0;
    rst  = 1'b0;
  endtask

  task automatic test_scan();
    exp_t e;
    int   first_fr = -1;
    for (int i = 0; i < 45; i++) begin
      next_cycle(e);
      checks++;
      if ({an, nibble, frame, pend} !== e) begin
        errors++; $display("FAIL scan c%0d got=%h exp=%h", i, {an, nibble, frame, pend}, e);
      end
      if (frame === 1'b1 && first_fr < 0) first_fr = i;
    end
    checks++;
    if (first_fr !== 20) begin errors++; $display("FAIL first_frame got=%0d exp=20", first_fr); end
  endtask

  task automatic test_load();
    exp_t e;
    load = 1'b1;
    data = 16'hA5C3;
    for (int i = 0; i < 40; i++) begin
      next_cycle(e);
      load = 1'b0;
      checks++;
      if ({an, nibble, frame, pend} !== e) begin
        errors++; $display("FAIL load c%0d got=%h exp=%h", i, {an, nibble, frame, pend}, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit   saw_one = 1'b0;
    for (int i = 0; i < 45; i++) begin
      load = (i == 0) || (i == 5);
      data = (i == 0) ? 16'h1111 : 16'h2222;
      next_cycle(e);
      checks++;
      if ({an, nibble, frame, pend} !== e) begin
        errors++; $display("FAIL b2b c%0d got=%h exp=%h", i, {an, nibble, frame, pend}, e);
      end
      if (an !== 4'hF && nibble === 4'h1) saw_one = 1'b1;
    end
    load = 1'b0;
    checks++;
    if (saw_one !== 1'b0) begin errors++; $display("FAIL b2b_stale got=%b exp=0", saw_one); end
  endtask

  task automatic test_boundary_load();
    exp_t e;
    bit   found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      next_cycle(e);
      checks++;
      if ({an, nibble, frame, pend} !== e) begin
        errors++; $display("FAIL bnd_wait c%0d got=%h exp=%h", i, {an, nibble, frame, pend}, e);
      end
      if (m_pos == FRAME - 1) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL bnd_timeout got=0 exp=1"); end
    load = 1'b1;
    data = 16'hBEEF;
    for (int i = 0; i < FRAME + 2; i++) begin
      next_cycle(e);
      load = 1'b0;
      checks++;
      if ({an, nibble, frame, pend} !== e) begin
        errors++; $display("FAIL bnd c%0d got=%h exp=%h", i, {an, nibble, frame, pend}, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit   loaded = 1'b0;
    bit   hit = 1'b0;
    for (int i = 0; i < 3 * FRAME && !hit; i++) begin
      load = (m_pos == 2) && !loaded;
      data = 16'h1357;
      if (load) loaded = 1'b1;
      next_cycle(e);
      checks++;
      if ({an, nibble, frame, pend} !== e) begin
        errors++; $display("FAIL rmid_wait c%0d got=%h exp=%h", i, {an, nibble, frame, pend}, e);
      end
      if (loaded && m_pos == 2 * SLOT + DIV) hit = 1'b1;
    end
    load = 1'b0;
    checks++;
    if (!hit) begin errors++; $display("FAIL rmid_timeout got=0 exp=1"); end
    rst = 1'b1;
    #1;
    checks++; if (an !== 4'hF)     begin errors++; $display("FAIL rmid_an got=%b exp=1111", an); end
    checks++; if (nibble !== 4'h0) begin errors++; $display("FAIL rmid_nibble got=%h exp=0", nibble); end
    checks++; if (pend !== 1'b0)   begin errors++; $display("FAIL rmid_pend got=%b exp=0", pend); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < FRAME + 3; i++) begin
      next_cycle(e);
      checks++;
      if ({an, nibble, frame, pend} !== e) begin
        errors++; $display("FAIL rmid c%0d got=%h exp=%h", i, {an, nibble, frame, pend}, e);
      end
    end
  endtask

`ifdef SS_SCAN_LZB_EN
  task automatic test_lzb();
    exp_t        e;
    logic [15:0] pat[2] = '{16'h0070, 16'h0000};
    for (int p = 0; p < 2; p++) begin
      load = 1'b1;
      data = pat[p];
      for (int i = 0; i < 2 * FRAME + 2; i++) begin
        next_cycle(e);
        load = 1'b0;
        checks++;
        if ({an, nibble, frame, pend} !== e) begin
          errors++; $display("FAIL lzb%0d c%0d got=%h exp=%h", p, i, {an, nibble, frame, pend}, e);
        end
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_scan();
    test_load();
    test_back_to_back();
    test_boundary_load();
    test_reset_mid();
`ifdef SS_SCAN_LZB_EN
    test_lzb();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
